// File: rtl/reg_file_32x64_pkg.sv
// Shared types and sizing for the 32 x 64-bit architectural register file.
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;

  typedef logic [4:0]        reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_file_32x64_if.sv
// Register-file bus: one write port and two independent read ports.
// Signal semantics: there is no valid/ready pair. wr_en is a one-cycle write
// strobe that is always accepted at the next rising edge, and each read port
// is a combinational lookup whose data is valid whenever its address is.
interface regfile_if;
  import regfile_pkg::*;

  logic      wr_en;
  reg_addr_t wr_addr;
  word_t     wr_data;
  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  word_t     rd_data_a;
  word_t     rd_data_b;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b
  );
endinterface

// File: rtl/decode32_1.sv
// 5-to-32 one-hot decoder with enable (decoder library cell).
module decode32_1 (
  input  logic        en_i,
  input  logic [4:0]  sel_i,
  output logic [31:0] onehot_o
);
  assign onehot_o = en_i ? (32'd1 << sel_i) : 32'd0;
endmodule

// File: rtl/reg_file_32x64.sv
// 32 x 64-bit register file, two combinational read ports, one write port; XZR (reg 31) is zero.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data onto matching read ports.
module reg_file_32x64
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  regfile_if.slave bus
);

  logic [NUM_REGS-1:0] we_vec;
  word_t               store_q [NUM_REGS];
  word_t               store_d [NUM_REGS];
  word_t               arr_a;
  word_t               arr_b;

  decode32_1 u_wr_dec (
    .en_i     (bus.wr_en),
    .sel_i    (bus.wr_addr),
    .onehot_o (we_vec)
  );

  // The XZR slot is forced to zero every cycle, so it folds to a constant.
  always_comb begin
    store_d = store_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i == ZERO_REG) begin
        store_d[i] = '0;
      end else if (we_vec[i]) begin
        store_d[i] = bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      store_q <= store_d;
    end
  end

  assign arr_a = store_q[bus.rd_addr_a];
  assign arr_b = store_q[bus.rd_addr_b];

`ifdef REGFILE_BYPASS_EN
  logic byp_ok;
  assign byp_ok = reset_n && bus.wr_en && (bus.wr_addr != reg_addr_t'(ZERO_REG));
  assign bus.rd_data_a = (byp_ok && (bus.rd_addr_a == bus.wr_addr)) ? bus.wr_data : arr_a;
  assign bus.rd_data_b = (byp_ok && (bus.rd_addr_b == bus.wr_addr)) ? bus.wr_data : arr_b;
`else
  assign bus.rd_data_a = arr_a;
  assign bus.rd_data_b = arr_b;
`endif

endmodule
